// File: rtl/lsu_pkg.sv
// Shared types for the load/store data memory: access sizes, response FSM
// states and the per-size byte mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Right-aligned byte-enable pattern for an access of the given size.
  function automatic logic [7:0] size_mask(size_e sz);
    logic [7:0] m;
    m = 8'h00;
    unique case (sz)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0F;
      SZ_D: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_ram_be.sv
// DEPTH x WIDTH single-port array with per-byte write enables and a
// registered read port; contents are not touched by reset.
module lsu_ram_be #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  output logic [WIDTH-1:0]         rdata
);

  localparam int NB = int'(WIDTH / 8);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store data memory with a valid/ready request channel and a one-entry
// response holding register; handles alignment, range errors and load extension.
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_err
);

  localparam int unsigned NB     = WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  state_e            state_q, state_d;
  size_e             req_sz, size_q;
  logic [LANE_W-1:0] lane, lane_q;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned, out_of_range, bad_size, err, accept;
  logic              load_q, uns_q, err_q;
  logic [7:0]        mask8;
  logic [NB-1:0]     be;
  logic              ram_we, ram_re;
  logic [WIDTH-1:0]  ram_wdata, ram_rdata, shifted, keep, ext;
  logic              sign;

  assign req_sz   = size_e'(req_size);
  assign lane     = req_addr[LANE_W-1:0];
  assign word_idx = req_addr >> LANE_W;

  always_comb begin
    misaligned = 1'b0;
    unique case (req_sz)
      SZ_B: misaligned = 1'b0;
      SZ_H: misaligned = req_addr[0];
      SZ_W: misaligned = |req_addr[1:0];
      SZ_D: misaligned = |req_addr[2:0];
    endcase
  end

  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign bad_size     = (req_sz == SZ_D) && (WIDTH == 32);
  assign err          = misaligned | out_of_range | bad_size;

  assign resp_valid = (state_q == RESP);
  assign req_ready  = !resp_valid || resp_ready;
  // Nothing is accepted while reset is held, even though ready reads 1.
  assign accept     = req_valid && req_ready && rst_n;

  assign mask8     = size_mask(req_sz);
  assign be        = mask8[NB-1:0] << lane;
  assign ram_wdata = req_wdata << {lane, 3'b000};
  assign ram_we    = accept && req_we && !err;
  assign ram_re    = accept && !req_we && !err;

  lsu_ram_be #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .addr (word_idx[IDX_W-1:0]),
    .wdata(ram_wdata),
    .re   (ram_re),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: begin
        if (accept) state_d = RESP;
        else if (resp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        load_q <= !req_we && !err;
        uns_q  <= req_unsigned;
        err_q  <= err;
        size_q <= req_sz;
        lane_q <= lane;
      end
    end
  end

  // The RAM output register holds the whole word; lane select and extension
  // are applied from the request attributes captured alongside it.
  always_comb begin
    shifted = ram_rdata >> {lane_q, 3'b000};
    keep    = '1;
    sign    = 1'b0;
    unique case (size_q)
      SZ_B: begin keep = WIDTH'(8'hFF);         sign = shifted[7];  end
      SZ_H: begin keep = WIDTH'(16'hFFFF);      sign = shifted[15]; end
      SZ_W: begin keep = WIDTH'(32'hFFFF_FFFF); sign = shifted[31]; end
      SZ_D: begin keep = '1;                    sign = 1'b0;        end
    endcase
    ext = shifted & keep;
    if (!uns_q && sign) ext = ext | ~keep;
  end

  assign resp_rdata = (resp_valid && load_q) ? ext : '0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits; only 32 and 64 are legal.
REQ-002 The block SHALL have parameter DEPTH, default 512, giving the number of WIDTH-bit words; it is a power of two.
REQ-003 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-009 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 double.
REQ-010 The block SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-011 The block SHALL have port req_addr, input, ADDR_W bits: the byte address.
REQ-012 The block SHALL have port req_wdata, input, WIDTH bits: store data, right-aligned (bits [n-1:0] are stored).
REQ-013 The block SHALL have port resp_valid, output, 1 bit: a response is held.
REQ-014 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-015 The block SHALL have port resp_rdata, output, WIDTH bits: the load result, extended per req_size and req_unsigned.
REQ-016 The block SHALL have port resp_err, output, 1 bit: the access was misaligned, out of range, or used an illegal size.

Function
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 req_ready SHALL be driven combinationally as !resp_valid || resp_ready.
REQ-019 The FSM SHALL have two states, IDLE and RESP. An accept moves it to RESP. In RESP, resp_ready=1 with no new accept moves it to IDLE; resp_ready=1 together with an accept keeps it in RESP.
REQ-020 resp_valid SHALL be 1 exactly in RESP, asserted the cycle after the accept, and held with resp_rdata and resp_err stable until resp_ready=1.
REQ-021 Back-to-back accepts SHALL sustain one response per cycle when resp_ready is held at 1.
REQ-022 Word index SHALL be req_addr >> log2(WIDTH/8); the byte lane SHALL be req_addr[log2(WIDTH/8)-1:0].
REQ-023 Error conditions SHALL be: the address is not aligned to the access size; the word index is >= DEPTH; or req_size=11 when WIDTH=32.
REQ-024 An erroring store SHALL leave the memory unchanged; an erroring load SHALL return resp_rdata=0; both SHALL set resp_err=1.
REQ-025 A legal store SHALL write only the addressed byte lanes, using per-byte enables in a single cycle with no read-modify-write; the other lanes are preserved.
REQ-026 A store response SHALL return resp_rdata=0 and resp_err=0.
REQ-027 A legal load SHALL return the addressed bytes shifted to bit 0, then sign- or zero-extended to WIDTH.
REQ-028 Each response's data and error SHALL be captured at the accept edge, independent of later request-side changes.
REQ-029 A load accepted in the cycle after a store to the same word SHALL return the stored data; memory is written at the store's accept edge.
REQ-030 Memory contents SHALL power up to 0, SHALL NOT be cleared by reset, and SHALL be read synchronously on the accept edge.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force state to IDLE, resp_valid=0, resp_err=0 and resp_rdata=0, independent of clk.
REQ-032 A response pending when reset asserts SHALL be dropped.
REQ-033 While rst_n=0, req_ready SHALL be 1, but no request SHALL be accepted and no store SHALL be written.
REQ-034 The first accept after reset SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-035 A shared package lsu_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W, SZ_D) and the state enum (IDLE, RESP).
REQ-036 One sub-module, lsu_ram_be, SHALL implement the DEPTH x WIDTH array with byte-write enables and a synchronous read port.
REQ-037 The alignment check, error decode and load extension SHALL be combinational logic in lsu_data_mem.

Verification
REQ-038 Scenario: reset, then SW 0xDEADBEEF to address 0x10, then LW from 0x10 -> the LW response has resp_rdata=0xDEADBEEF and resp_err=0.
REQ-039 Scenario: SB 0x80 to address 0x11, then LB from 0x11 -> 0xFFFFFF80; LBU from 0x11 -> 0x00000080; LW from 0x10 -> 0xDEAD80EF.
REQ-040 Scenario: LH from 0x13, SW to 0x12, and LW from byte address 0x800 with DEPTH=512 -> each gives resp_err=1 and resp_rdata=0, and the memory is unchanged.
REQ-041 Scenario: resp_ready held at 0 for 3 cycles after a load -> req_ready=0, resp_valid and resp_rdata stay stable, and a second req_valid is not accepted until the cycle resp_ready=1.
REQ-042 Scenario: rst_n pulsed low mid-cycle while in RESP -> resp_valid falls immediately, and a following LW from 0x10 still returns 0xDEAD80EF.
REQ-043 Scenario: WIDTH=64, SD 0x0123456789ABCDEF to 0x8, then LH from 0xE -> 0x0000000000000123; SD with WIDTH=32 -> resp_err=1.
